rx_command_sequencer: RTL and testbench

//  Sits behind rx_serial_8N1: takes each received byte (pronto/dados_ascii), frames

---
 rtl/rx_command_sequencer_if.sv | 28 ++
 rtl/rx_command_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_rx_command_sequencer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_command_sequencer_if.sv
// Byte-input and move-output signal bundle for rx_command_sequencer.
// slave  : the sequencer itself (takes received bytes, offers moves).
// master : the environment (UART receiver side plus motion executor).
interface rx_command_sequencer_if;
   logic       rx_pronto;
   logic [7:0] rx_dados;
   logic       move_valid;
   logic [7:0] move_data;
   logic       move_ready;
   logic       busy;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       rx_dropped;
   logic [3:0] db_estado;

   modport slave (
      input  rx_pronto, rx_dados, move_ready,
      output move_valid, move_data, busy, frame_ok, frame_err,
             err_code, rx_dropped, db_estado
   );

   modport master (
      output rx_pronto, rx_dados, move_ready,
      input  move_valid, move_data, busy, frame_ok, frame_err,
             err_code, rx_dropped, db_estado
   );
endinterface

// File: rtl/rx_command_sequencer.sv
// Frames "#<moves>;" cube-move commands from a byte stream, buffers a valid
// frame and then issues its moves one by one over a valid/ready handshake.
// Bad characters, empty/oversized frames and inter-byte stalls discard the frame.
module rx_command_sequencer #(
   parameter int MAX_MOVES      = 32,
   parameter int TIMEOUT_CYCLES = 434000
) (
   input logic                   clock,
   input logic                   reset,
   rx_command_sequencer_if.slave bus
);

   localparam int IDX_W = $clog2(MAX_MOVES);
   localparam int CNT_W = IDX_W + 1;
   localparam int TO_W  = $clog2(TIMEOUT_CYCLES);

   localparam logic [CNT_W-1:0] FULL    = CNT_W'(MAX_MOVES);
   localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]       CH_HASH = 8'h23;
   localparam logic [7:0]       CH_SEMI = 8'h3B;

   typedef enum logic [3:0] {
      S_IDLE    = 4'd0,
      S_RECEIVE = 4'd1,
      S_EXECUTE = 4'd2,
      S_ERROR   = 4'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE    = 2'b00,
      ERR_CHAR    = 2'b01,
      ERR_LEN     = 2'b10,
      ERR_TIMEOUT = 2'b11
   } err_t;

   state_t           state;
   err_t             err_code_q;
   logic             rx_prev;
   logic [CNT_W-1:0] wr_cnt;
   logic [CNT_W-1:0] rd_idx;
   logic [TO_W-1:0]  to_cnt;
   logic             move_valid_q;
   logic [7:0]       move_data_q;
   logic             frame_ok_q;
   logic             frame_err_q;
   logic             rx_dropped_q;
   logic [7:0]       buffer [MAX_MOVES];

   logic             byte_acc;
   logic             rx_is_move;
   logic             buf_we;
   logic             last_move;
   logic [CNT_W-1:0] next_rd;

   function automatic logic is_move(input logic [7:0] c);
      case (c)
         "U", "D", "L", "R", "F", "B",
         "u", "d", "l", "r", "f", "b": return 1'b1;
         default:                      return 1'b0;
      endcase
   endfunction

   // A byte is taken once, on the rising edge of the receiver strobe.
   assign byte_acc   = bus.rx_pronto & ~rx_prev;
   assign rx_is_move = is_move(bus.rx_dados);
   assign buf_we     = (state == S_RECEIVE) && byte_acc && rx_is_move && (wr_cnt != FULL);
   assign next_rd    = rd_idx + CNT_W'(1);
   assign last_move  = (rd_idx == wr_cnt - CNT_W'(1));

   assign bus.move_valid = move_valid_q;
   assign bus.move_data  = move_data_q;
   assign bus.frame_ok   = frame_ok_q;
   assign bus.frame_err  = frame_err_q;
   assign bus.err_code   = err_code_q;
   assign bus.rx_dropped = rx_dropped_q;
   assign bus.db_estado  = state;
   assign bus.busy       = (state == S_RECEIVE) || (state == S_EXECUTE);

   // Move storage: written while a frame is received, read during execution.
   // NOTE: the buffer holds data only and is never read before being written
   // within a frame, so it carries no reset and can map onto plain RAM/regs.
   always_ff @(posedge clock) begin
      if (buf_we) begin
         buffer[wr_cnt[IDX_W-1:0]] <= bus.rx_dados;
      end
   end

   // Frame sequencer: state, counters and all registered outputs.
   // NOTE: every register here uses non-blocking assignment so all updates
   // in a cycle see the same pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state        <= S_IDLE;
         err_code_q   <= ERR_NONE;
         rx_prev      <= 1'b0;
         wr_cnt       <= '0;
         rd_idx       <= '0;
         to_cnt       <= '0;
         move_valid_q <= 1'b0;
         move_data_q  <= 8'h00;
         frame_ok_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_dropped_q <= 1'b0;
      end else begin
         rx_prev      <= bus.rx_pronto;
         frame_ok_q   <= 1'b0;
         frame_err_q  <= 1'b0;
         rx_dropped_q <= 1'b0;

         case (state)
            S_IDLE: begin
               if (byte_acc && bus.rx_dados == CH_HASH) begin
                  state      <= S_RECEIVE;
                  wr_cnt     <= '0;
                  to_cnt     <= '0;
                  err_code_q <= ERR_NONE;
               end
            end

            S_RECEIVE: begin
               if (byte_acc) begin
                  // A byte arriving in the timeout cycle still counts.
                  to_cnt <= '0;
                  if (rx_is_move) begin
                     if (wr_cnt == FULL) begin
                        state       <= S_ERROR;
                        err_code_q  <= ERR_LEN;
                        frame_err_q <= 1'b1;
                     end else begin
                        wr_cnt <= wr_cnt + CNT_W'(1);
                     end
                  end else if (bus.rx_dados == CH_HASH) begin
                     wr_cnt <= '0;
                  end else if (bus.rx_dados == CH_SEMI) begin
                     if (wr_cnt == '0) begin
                        state       <= S_ERROR;
                        err_code_q  <= ERR_LEN;
                        frame_err_q <= 1'b1;
                     end else begin
                        state        <= S_EXECUTE;
                        rd_idx       <= '0;
                        frame_ok_q   <= 1'b1;
                        move_valid_q <= 1'b1;
                        move_data_q  <= buffer[0];
                     end
                  end else begin
                     state       <= S_ERROR;
                     err_code_q  <= ERR_CHAR;
                     frame_err_q <= 1'b1;
                  end
               end else if (to_cnt == TO_LAST) begin
                  state       <= S_ERROR;
                  err_code_q  <= ERR_TIMEOUT;
                  frame_err_q <= 1'b1;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
            end

            S_ERROR: begin
               state <= S_IDLE;
            end

            S_EXECUTE: begin
               if (byte_acc) begin
                  rx_dropped_q <= 1'b1;
               end
               if (move_valid_q && bus.move_ready) begin
                  if (last_move) begin
                     move_valid_q <= 1'b0;
                     state        <= S_IDLE;
                  end else begin
                     rd_idx      <= next_rd;
                     move_data_q <= buffer[next_rd[IDX_W-1:0]];
                  end
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rx_command_sequencer.sv
// Scoreboard bench for rx_command_sequencer: a byte-level frame model pushes
// expected events (frame_ok, frame_err+code, moves); a monitor pops and compares.
module tb_rx_command_sequencer;

   localparam int MAX_MOVES      = 32;
   localparam int TIMEOUT_CYCLES = 200;

   logic clock = 1'b0;
   logic reset = 1'b0;

   rx_command_sequencer_if bus ();

   rx_command_sequencer #(
      .MAX_MOVES     (MAX_MOVES),
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   typedef enum int {EV_OK, EV_ERR, EV_MOVE} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [7:0] data;
      int         when;   // expected sample cycle, 0 = not checked
   } ev_t;

   ev_t        sb [$];
   logic [7:0] m_moves [$];
   bit         m_in_frame = 1'b0;
   int         hs_cyc [$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_drive_cyc = 0;
   int drops_expected = 0;
   int drops_seen = 0;
   int ready_mode = 1;     // 0 hold low, 1 hold high, 2 random
   bit mon_en = 1'b0;

   logic [7:0] move_tbl [12] = '{"U", "D", "L", "R", "F", "B", "u", "d", "l", "r", "f", "b"};
   logic [7:0] bad_tbl  [4]  = '{"X", "a", "0", " "};

   always @(posedge clock) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void push_ev(ev_kind_t k, logic [7:0] d, int w);
      ev_t e;
      e.kind = k;
      e.data = d;
      e.when = w;
      sb.push_back(e);
   endfunction

   function automatic bit is_move_ch(logic [7:0] c);
      foreach (move_tbl[i]) if (move_tbl[i] == c) return 1'b1;
      return 1'b0;
   endfunction

   // Frame rules applied to one accepted byte.
   function automatic void model_byte(logic [7:0] b, int acc_cyc, bit executing);
      if (executing) begin
         drops_expected++;
         return;
      end
      if (!m_in_frame) begin
         if (b == "#") begin
            m_in_frame = 1'b1;
            m_moves.delete();
         end
         return;
      end
      if (b == "#") begin
         m_moves.delete();
      end else if (is_move_ch(b)) begin
         if (m_moves.size() == MAX_MOVES) begin
            push_ev(EV_ERR, 8'd2, 0);
            m_in_frame = 1'b0;
         end else begin
            m_moves.push_back(b);
         end
      end else if (b == ";") begin
         if (m_moves.size() == 0) begin
            push_ev(EV_ERR, 8'd2, 0);
         end else begin
            push_ev(EV_OK, 8'd0, acc_cyc);
            foreach (m_moves[i]) push_ev(EV_MOVE, m_moves[i], 0);
         end
         m_in_frame = 1'b0;
      end else begin
         push_ev(EV_ERR, 8'd1, 0);
         m_in_frame = 1'b0;
      end
   endfunction

   task automatic send_byte(input logic [7:0] b, input int hold);
      bit exec;
      @(posedge clock);
      #1;
      exec = 1'b0;
      foreach (sb[i]) if (sb[i].kind == EV_MOVE) exec = 1'b1;
      last_drive_cyc = cyc;
      model_byte(b, cyc + 1, exec);
      bus.rx_dados  = b;
      bus.rx_pronto = 1'b1;
      repeat (hold) @(posedge clock);
      #1;
      bus.rx_pronto = 1'b0;
      bus.rx_dados  = 8'($urandom);
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i], $urandom_range(1, 2));
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (n < 3000) begin
         @(negedge clock);
         if (!bus.busy && sb.size() == 0) break;
         n++;
      end
      check("idle_reached", 32'(n < 3000), 1);
      check("idle_state", bus.db_estado, 0);
   endtask

   // Executor-side ready generator.
   initial begin
      bus.move_ready = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         case (ready_mode)
            0:       bus.move_ready = 1'b0;
            1:       bus.move_ready = 1'b1;
            default: bus.move_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor: pops expected events whenever the DUT presents a response.
   always @(negedge clock) begin : monitor
      ev_t        e;
      static bit         stalled_prev = 1'b0;
      static bit         hs_prev = 1'b0;
      static logic [7:0] prev_data = 8'h00;
      if (!mon_en) begin
         stalled_prev = 1'b0;
         hs_prev      = 1'b0;
      end else begin
         if (bus.frame_ok || bus.frame_err)
            check("ok_err_exclusive", 32'(bus.frame_ok & bus.frame_err), 0);
         if (bus.frame_ok) begin
            if (sb.size() == 0) check("unexpected_frame_ok", 1, 0);
            else begin
               e = sb.pop_front();
               check("frame_ok_kind", int'(e.kind), int'(EV_OK));
               check("frame_ok_latency", cyc, e.when);
            end
         end
         if (bus.frame_err) begin
            if (sb.size() == 0) check("unexpected_frame_err", 1, 0);
            else begin
               e = sb.pop_front();
               check("frame_err_kind", int'(e.kind), int'(EV_ERR));
               check("err_code", bus.err_code, e.data);
               if (e.when != 0) check("frame_err_time", cyc, e.when);
            end
         end
         if (stalled_prev) begin
            check("stall_valid_held", bus.move_valid, 1);
            check("stall_data_stable", bus.move_data, prev_data);
         end
         if (hs_prev && sb.size() > 0 && sb[0].kind == EV_MOVE)
            check("no_bubble", bus.move_valid, 1);
         if (bus.move_valid) begin
            check("move_expected", 32'(sb.size() > 0 && sb[0].kind == EV_MOVE), 1);
            if (bus.move_ready && sb.size() > 0 && sb[0].kind == EV_MOVE) begin
               e = sb.pop_front();
               check("move_data", bus.move_data, e.data);
               hs_cyc.push_back(cyc);
            end
         end
         if (bus.rx_dropped) drops_seen++;
         stalled_prev = bus.move_valid && !bus.move_ready;
         hs_prev      = bus.move_valid && bus.move_ready;
         prev_data    = bus.move_data;
      end
   end

   initial begin : watchdog
      #600000;
      $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin : stimulus
      int ok_c;
      int t_expect;
      logic [7:0] fr [$];

      bus.rx_pronto = 1'b0;
      bus.rx_dados  = 8'h00;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check("rst_move_valid", bus.move_valid, 0);
      check("rst_move_data", bus.move_data, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_frame_ok", bus.frame_ok, 0);
      check("rst_frame_err", bus.frame_err, 0);
      check("rst_err_code", bus.err_code, 0);
      check("rst_rx_dropped", bus.rx_dropped, 0);
      check("rst_state", bus.db_estado, 0);
      reset = 1'b1;
      #1 mon_en = 1'b1;

      // Basic frame, executor always ready: moves on consecutive cycles.
      ready_mode = 1;
      hs_cyc.delete();
      send_str("#UrF;");
      ok_c = last_drive_cyc + 1;
      wait_idle();
      check("hs_count", hs_cyc.size(), 3);
      for (int i = 0; i < 3 && i < hs_cyc.size(); i++)
         check("hs_cycle", hs_cyc[i], ok_c + i);

      // Stalled executor: first move held, byte during EXECUTE dropped.
      ready_mode = 0;
      send_str("#UD;");
      repeat (10) @(negedge clock);
      check("stall_valid", bus.move_valid, 1);
      check("stall_data", bus.move_data, "U");
      send_byte("L", 1);
      repeat (4) @(negedge clock);
      check("drop_count", drops_seen, drops_expected);
      check("stall_data_after_drop", bus.move_data, "U");
      ready_mode = 1;
      wait_idle();

      // Bad char, then a clean frame clears the code.
      send_str("#UX;");
      wait_idle();
      check("err_code_held_char", bus.err_code, 1);
      send_str("#B;");
      wait_idle();
      check("err_code_cleared", bus.err_code, 0);

      // Length errors: empty, full (accepted), overflow.
      send_str("#;");
      wait_idle();
      check("err_code_empty", bus.err_code, 2);
      ready_mode = 2;
      send_byte("#", 1);
      for (int i = 0; i < MAX_MOVES; i++) send_byte(move_tbl[$urandom_range(0, 11)], 1);
      send_byte(";", 1);
      wait_idle();
      check("err_code_full_ok", bus.err_code, 0);
      send_byte("#", 1);
      for (int i = 0; i < MAX_MOVES + 1; i++) send_byte(move_tbl[$urandom_range(0, 11)], 1);
      send_byte(";", 1);
      wait_idle();
      check("err_code_overflow", bus.err_code, 2);

      // Inter-byte timeout.
      send_str("#U");
      t_expect = last_drive_cyc + 1 + TIMEOUT_CYCLES;
      push_ev(EV_ERR, 8'd3, t_expect);
      m_in_frame = 1'b0;
      repeat (TIMEOUT_CYCLES + 10) @(negedge clock);
      wait_idle();
      check("err_code_timeout", bus.err_code, 3);

      // Restart inside a frame.
      ready_mode = 1;
      hs_cyc.delete();
      send_str("#LL#R;");
      wait_idle();
      check("restart_moves", hs_cyc.size(), 1);

      // Randomized frames with random executor backpressure.
      ready_mode = 2;
      for (int f = 0; f < 40; f++) begin
         fr.delete();
         if ($urandom_range(0, 9) == 0) begin
            fr.push_back(8'h0D);
            fr.push_back(8'h0A);
         end
         fr.push_back("#");
         for (int i = $urandom_range(0, MAX_MOVES + 2); i > 0; i--) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 92)      fr.push_back(move_tbl[$urandom_range(0, 11)]);
            else if (r < 96) fr.push_back("#");
            else             fr.push_back(bad_tbl[$urandom_range(0, 3)]);
         end
         fr.push_back(";");
         foreach (fr[i]) send_byte(fr[i], $urandom_range(1, 3));
         wait_idle();
      end

      // Reset asserted mid-EXECUTE clears everything immediately.
      ready_mode = 0;
      send_str("#RFL;");
      repeat (3) @(negedge clock);
      check("pre_reset_valid", bus.move_valid, 1);
      #2;
      reset  = 1'b0;
      mon_en = 1'b0;
      #1;
      check("mid_rst_move_valid", bus.move_valid, 0);
      check("mid_rst_move_data", bus.move_data, 0);
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_frame_ok", bus.frame_ok, 0);
      check("mid_rst_frame_err", bus.frame_err, 0);
      check("mid_rst_state", bus.db_estado, 0);
      sb.delete();
      m_moves.delete();
      m_in_frame = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      #1 mon_en = 1'b1;
      ready_mode = 1;
      send_str("#B;");
      wait_idle();

      check("scoreboard_drained", sb.size(), 0);
      check("drops_total", drops_seen, drops_expected);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
